// File: rtl/systolic_feeder.sv
// -----------------------------------------------------------------------------
// systolic_feeder
//
// Holds one N x N activation tile A and one N x N weight tile W, then streams
// them into the edges of an N x N systolic array with the usual diagonal skew.
// Row i of A enters PE row i delayed by i cycles. Column j of W enters PE
// column j delayed by j cycles.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset (clears FSM, outputs, buffers)
//   en         global enable; when low every register holds
//   wr_en      tile-buffer write strobe (accepted only while idle)
//   wr_sel     0 = activation buffer A, 1 = weight buffer W
//   wr_addr    entry index row*N + col (A[i][k] or W[k][j])
//   wr_data    write data
//   start      begin feeding the stored tile (ignored while busy)
//   busy       high while feeding and during the done cycle
//   act_out    N lanes of DW bits, lane i drives the left edge of PE row i
//   wgt_out    N lanes of DW bits, lane j drives the top of PE column j
//   act_done   per-row input_done pulse
//   wgt_done   per-column input_done pulse
//   done       one-cycle tile-complete pulse
//   state_dbg  current FSM state (0 idle, 1 feed, 2 done) for observation
//
// Handshake: there is no back-pressure. A write is taken on any enabled edge
// with wr_en high while idle. A start is taken on any enabled edge with start
// high while idle. Both are silently dropped while busy.
// -----------------------------------------------------------------------------
module systolic_feeder #(
   parameter int N  = 4,
   parameter int DW = 16
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            en,
   input  logic            wr_en,
   input  logic            wr_sel,
   input  logic [3:0]      wr_addr,
   input  logic [DW-1:0]   wr_data,
   input  logic            start,
   output logic            busy,
   output logic [N*DW-1:0] act_out,
   output logic [N*DW-1:0] wgt_out,
   output logic [N-1:0]    act_done,
   output logic [N-1:0]    wgt_done,
   output logic            done,
   output logic [1:0]      state_dbg
);

   localparam int TW = $clog2(2 * N);
   localparam int AW = (N * N > 1) ? $clog2(N * N) : 1;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_FEED = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   localparam logic [TW-1:0] T_LAST = TW'(2 * N - 1);

   // Tile buffers, row-major: a_mem_q[i*N+k] = A[i][k], w_mem_q[k*N+j] = W[k][j]
   logic [DW-1:0] a_mem_q [N*N];
   logic [DW-1:0] w_mem_q [N*N];

   logic [1:0]      state_q, state_d;
   logic [TW-1:0]   t_q, t_d;
   logic [N*DW-1:0] act_q, act_d;
   logic [N*DW-1:0] wgt_q, wgt_d;
   logic [N-1:0]    act_done_q, act_done_d;
   logic [N-1:0]    wgt_done_q, wgt_done_d;
   logic            done_q, done_d;
   logic            busy_q, busy_d;

   // Output values for the step that the next edge will load
   int              nstep;
   int              k;
   logic [N*DW-1:0] act_step;
   logic [N*DW-1:0] wgt_step;
   logic [N-1:0]    act_done_step;
   logic [N-1:0]    wgt_done_step;

   logic            wr_ok;

   assign wr_ok = en && wr_en && (state_q == S_IDLE);

   // Skewed lane selection. Lane i carries element t-i of its row/column when
   // that index lies in 0..N-1. At t == i+N the index is exactly N, so the
   // lane is zero in the same cycle its done flag rises.
   always_comb begin
      nstep         = (state_q == S_IDLE) ? 0 : int'(t_q) + 1;
      k             = 0;
      act_step      = '0;
      wgt_step      = '0;
      act_done_step = '0;
      wgt_done_step = '0;
      for (int i = 0; i < N; i++) begin
         k = nstep - i;
         if (k >= 0 && k < N) begin
            act_step[i*DW +: DW] = a_mem_q[AW'(i * N + k)];
            wgt_step[i*DW +: DW] = w_mem_q[AW'(k * N + i)];
         end
         act_done_step[i] = (nstep == i + N);
         wgt_done_step[i] = (nstep == i + N);
      end
   end

   // FSM next state. Every register holds unless en is high.
   always_comb begin
      state_d    = state_q;
      t_d        = t_q;
      act_d      = act_q;
      wgt_d      = wgt_q;
      act_done_d = act_done_q;
      wgt_done_d = wgt_done_q;
      done_d     = done_q;
      busy_d     = busy_q;
      if (en) begin
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  state_d    = S_FEED;
                  t_d        = '0;
                  act_d      = act_step;
                  wgt_d      = wgt_step;
                  act_done_d = act_done_step;
                  wgt_done_d = wgt_done_step;
                  done_d     = 1'b0;
                  busy_d     = 1'b1;
               end
            end
            S_FEED: begin
               if (t_q == T_LAST) begin
                  state_d    = S_DONE;
                  act_d      = '0;
                  wgt_d      = '0;
                  act_done_d = '0;
                  wgt_done_d = '0;
                  done_d     = 1'b1;
                  busy_d     = 1'b1;
               end else begin
                  t_d        = t_q + TW'(1);
                  act_d      = act_step;
                  wgt_d      = wgt_step;
                  act_done_d = act_done_step;
                  wgt_done_d = wgt_done_step;
               end
            end
            S_DONE: begin
               state_d    = S_IDLE;
               t_d        = '0;
               act_d      = '0;
               wgt_d      = '0;
               act_done_d = '0;
               wgt_done_d = '0;
               done_d     = 1'b0;
               busy_d     = 1'b0;
            end
            default: begin
               state_d    = S_IDLE;
               t_d        = '0;
               act_d      = '0;
               wgt_d      = '0;
               act_done_d = '0;
               wgt_done_d = '0;
               done_d     = 1'b0;
               busy_d     = 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_IDLE;
         t_q        <= '0;
         act_q      <= '0;
         wgt_q      <= '0;
         act_done_q <= '0;
         wgt_done_q <= '0;
         done_q     <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         t_q        <= t_d;
         act_q      <= act_d;
         wgt_q      <= wgt_d;
         act_done_q <= act_done_d;
         wgt_done_q <= wgt_done_d;
         done_q     <= done_d;
         busy_q     <= busy_d;
      end
   end

   // wr_addr is expected to stay below N*N; higher bits are not decoded.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int e = 0; e < N * N; e++) begin
            a_mem_q[e] <= '0;
            w_mem_q[e] <= '0;
         end
      end else if (wr_ok) begin
         if (wr_sel) begin
            w_mem_q[AW'(wr_addr)] <= wr_data;
         end else begin
            a_mem_q[AW'(wr_addr)] <= wr_data;
         end
      end
   end

   assign busy      = busy_q;
   assign act_out   = act_q;
   assign wgt_out   = wgt_q;
   assign act_done  = act_done_q;
   assign wgt_done  = wgt_done_q;
   assign done      = done_q;
   assign state_dbg = state_q;

endmodule

// File: tb/tb_systolic_feeder.sv
module tb_systolic_feeder;

   localparam int N  = 4;
   localparam int DW = 16;

   // clock / reset block
   logic            clk = 1'b0;
   logic            rst;
   logic            en;
   logic            wr_en;
   logic            wr_sel;
   logic [3:0]      wr_addr;
   logic [DW-1:0]   wr_data;
   logic            start;
   logic            busy;
   logic [N*DW-1:0] act_out;
   logic [N*DW-1:0] wgt_out;
   logic [N-1:0]    act_done;
   logic [N-1:0]    wgt_done;
   logic            done;
   logic [1:0]      state_dbg;

   always #5 clk = ~clk;

   systolic_feeder #(.N(N), .DW(DW)) dut (
      .clk       (clk),
      .rst       (rst),
      .en        (en),
      .wr_en     (wr_en),
      .wr_sel    (wr_sel),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .start     (start),
      .busy      (busy),
      .act_out   (act_out),
      .wgt_out   (wgt_out),
      .act_done  (act_done),
      .wgt_done  (wgt_done),
      .done      (done),
      .state_dbg (state_dbg)
   );

   int n_checks = 0;
   int n_fail   = 0;

   // reference copy of what the tile buffers should hold
   logic [DW-1:0] a_ref [N*N];
   logic [DW-1:0] w_ref [N*N];

   function automatic logic [N*DW-1:0] exp_act(input int s);
      logic [N*DW-1:0] r;
      r = '0;
      for (int i = 0; i < N; i++)
         if (s - i >= 0 && s - i < N) r[i*DW +: DW] = a_ref[i*N + (s - i)];
      return r;
   endfunction

   function automatic logic [N*DW-1:0] exp_wgt(input int s);
      logic [N*DW-1:0] r;
      r = '0;
      for (int j = 0; j < N; j++)
         if (s - j >= 0 && s - j < N) r[j*DW +: DW] = w_ref[(s - j)*N + j];
      return r;
   endfunction

   function automatic logic [N-1:0] exp_flags(input int s);
      logic [N-1:0] r;
      r = '0;
      for (int i = 0; i < N; i++)
         if (s == i + N) r[i] = 1'b1;
      return r;
   endfunction

   // driver tasks
   task automatic write_entry(input logic sel, input int addr, input logic [DW-1:0] data);
      wr_en   = 1'b1;
      wr_sel  = sel;
      wr_addr = 4'(addr);
      wr_data = data;
      @(posedge clk); #1;
      wr_en   = 1'b0;
      if (sel) w_ref[addr] = data;
      else     a_ref[addr] = data;
   endtask

   task automatic test_reset();
      rst = 1'b1; en = 1'b1; wr_en = 1'b0; wr_sel = 1'b0; wr_addr = '0; wr_data = '0; start = 1'b0;
      for (int e = 0; e < N * N; e++) begin
         a_ref[e] = '0;
         w_ref[e] = '0;
      end
      #2;
      n_checks++;
      if ({act_out, wgt_out, act_done, wgt_done, done, busy, state_dbg} !== '0) begin
         n_fail++;
         $display("FAIL reset_outputs: got act=%h wgt=%h ad=%b wd=%b done=%b busy=%b st=%0d want all 0",
                  act_out, wgt_out, act_done, wgt_done, done, busy, state_dbg);
      end
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      n_checks++;
      if ({busy, done} !== 2'b00) begin
         n_fail++;
         $display("FAIL reset_exit_idle: got busy=%b done=%b want 0 0", busy, done);
      end
   endtask

   task automatic test_load();
      for (int i = 0; i < N; i++)
         for (int kk = 0; kk < N; kk++)
            write_entry(1'b0, i*N + kk, 16'h1000 + 16'(16*i + kk));
      for (int kk = 0; kk < N; kk++)
         for (int j = 0; j < N; j++)
            write_entry(1'b1, kk*N + j, 16'h2000 + 16'(16*kk + j));
   endtask

   // Runs one tile from start, checking every step against the reference.
   task automatic run_tile(input string tag, input bit nominal, input int hold_step,
                           input bit poke, input int abort_step);
      logic [N*DW-1:0] ea, ew;
      logic [N-1:0]    ef;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      for (int s = 0; s < 2*N; s++) begin
         ea = exp_act(s);
         ew = exp_wgt(s);
         ef = exp_flags(s);
         n_checks++;
         if (act_out !== ea) begin
            n_fail++;
            $display("FAIL %s act step %0d: got %h want %h", tag, s, act_out, ea);
         end
         n_checks++;
         if (wgt_out !== ew) begin
            n_fail++;
            $display("FAIL %s wgt step %0d: got %h want %h", tag, s, wgt_out, ew);
         end
         n_checks++;
         if ({act_done, wgt_done} !== {ef, ef}) begin
            n_fail++;
            $display("FAIL %s flags step %0d: got ad=%b wd=%b want %b %b", tag, s, act_done, wgt_done, ef, ef);
         end
         n_checks++;
         if ({busy, done} !== 2'b10) begin
            n_fail++;
            $display("FAIL %s busy_done step %0d: got busy=%b done=%b want 1 0", tag, s, busy, done);
         end
         if (nominal) begin
            case (s)
               0: begin
                  n_checks++;
                  if (act_out !== 64'h0000_0000_0000_1000 || wgt_out[15:0] !== 16'h2000) begin
                     n_fail++;
                     $display("FAIL %s hand_step0: got act=%h wgt0=%h want 0000000000001000 2000", tag, act_out, wgt_out[15:0]);
                  end
               end
               3: begin
                  n_checks++;
                  if (act_out !== 64'h1030_1021_1012_1003) begin
                     n_fail++;
                     $display("FAIL %s hand_step3: got %h want 1030102110121003", tag, act_out);
                  end
               end
               4: begin
                  n_checks++;
                  if (act_done !== 4'b0001 || act_out[15:0] !== 16'h0000) begin
                     n_fail++;
                     $display("FAIL %s hand_step4: got ad=%b lane0=%h want 0001 0000", tag, act_done, act_out[15:0]);
                  end
               end
               7: begin
                  n_checks++;
                  if (act_done !== 4'b1000 || wgt_done !== 4'b1000) begin
                     n_fail++;
                     $display("FAIL %s hand_step7: got ad=%b wd=%b want 1000 1000", tag, act_done, wgt_done);
                  end
               end
               default: ;
            endcase
         end
         if (s == abort_step) begin
            #3 rst = 1'b1;
            #1;
            n_checks++;
            if ({act_out, wgt_out, act_done, wgt_done, done, busy} !== '0) begin
               n_fail++;
               $display("FAIL %s abort_zero: got act=%h wgt=%h ad=%b wd=%b done=%b busy=%b want all 0",
                        tag, act_out, wgt_out, act_done, wgt_done, done, busy);
            end
            #1 rst = 1'b0;
            for (int c = 0; c < 2*N + 2; c++) begin
               @(posedge clk); #1;
               n_checks++;
               if ({done, busy} !== 2'b00) begin
                  n_fail++;
                  $display("FAIL %s abort_no_done cycle %0d: got done=%b busy=%b want 0 0", tag, c, done, busy);
               end
            end
            return;
         end
         if (s == hold_step) begin
            en = 1'b0;
            for (int c = 0; c < 3; c++) begin
               @(posedge clk); #1;
               n_checks++;
               if ({act_out, wgt_out, act_done, wgt_done, busy, done} !== {ea, ew, ef, ef, 2'b10}) begin
                  n_fail++;
                  $display("FAIL %s hold cycle %0d: got act=%h wgt=%h ad=%b wd=%b want act=%h wgt=%h",
                           tag, c, act_out, wgt_out, act_done, wgt_done, ea, ew);
               end
            end
            en = 1'b1;
         end
         if (poke && s == 3) begin
            wr_en   = 1'b1;
            wr_sel  = 1'b0;
            wr_addr = 4'd0;
            wr_data = 16'hFFFF;
            start   = 1'b1;
         end
         @(posedge clk); #1;
         wr_en = 1'b0;
         start = 1'b0;
      end
      n_checks++;
      if ({done, busy, act_out, wgt_out, act_done, wgt_done} !== {2'b11, {(2*N*DW + 2*N){1'b0}}}) begin
         n_fail++;
         $display("FAIL %s done_cycle: got done=%b busy=%b act=%h wgt=%h ad=%b wd=%b want done=1 busy=1 rest 0",
                  tag, done, busy, act_out, wgt_out, act_done, wgt_done);
      end
      @(posedge clk); #1;
      n_checks++;
      if ({done, busy} !== 2'b00) begin
         n_fail++;
         $display("FAIL %s after_done: got done=%b busy=%b want 0 0", tag, done, busy);
      end
   endtask

   task automatic test_nominal();
      run_tile("nominal", 1'b1, -1, 1'b0, -1);
   endtask

   task automatic test_enable_hold();
      run_tile("en_hold", 1'b1, 2, 1'b0, -1);
   endtask

   task automatic test_write_start_while_busy();
      run_tile("busy_poke", 1'b1, -1, 1'b1, -1);
      @(posedge clk); #1;
      run_tile("after_poke", 1'b1, -1, 1'b0, -1);
   endtask

   task automatic test_back_to_back();
      int t_first, t_second, idle_cnt;
      t_first = -1; t_second = -1; idle_cnt = 0;
      start = 1'b1;
      for (int c = 0; c < 60 && t_second < 0; c++) begin
         @(posedge clk); #1;
         if (done) begin
            if (t_first < 0) t_first = c;
            else             t_second = c;
         end else if (t_first >= 0 && !busy) begin
            idle_cnt++;
         end
      end
      start = 1'b0;
      n_checks++;
      if (t_second < 0 || t_second - t_first != 2*N + 2) begin
         n_fail++;
         $display("FAIL b2b_period: got first=%0d second=%0d want spacing %0d", t_first, t_second, 2*N + 2);
      end
      n_checks++;
      if (idle_cnt != 1) begin
         n_fail++;
         $display("FAIL b2b_idle_gap: got %0d idle cycles want 1", idle_cnt);
      end
      repeat (2) @(posedge clk);
      #1;
      n_checks++;
      if (busy !== 1'b0) begin
         n_fail++;
         $display("FAIL b2b_settle: got busy=%b want 0", busy);
      end
   endtask

   task automatic test_mid_reset();
      run_tile("mid_reset", 1'b0, -1, 1'b0, 5);
      for (int e = 0; e < N * N; e++) begin
         a_ref[e] = '0;
         w_ref[e] = '0;
      end
      run_tile("zero_replay", 1'b0, -1, 1'b0, -1);
   endtask

   initial begin
      test_reset();
      test_load();
      test_nominal();
      test_enable_hold();
      test_write_start_while_busy();
      test_back_to_back();
      test_mid_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
